dcache_line_memory: RTL and testbench
=====================================

Name: dcache_line_memory

Overview:
- Backing-store responder on the memory side of the data cache.
- Serves whole-line fills (memRead) and whole-line writebacks (memWrite) over the cache's busy/line-data handshake.
- Holds DEPTH_LINES lines of BLOCK_SIZE bytes each.
- Models a fixed access latency with a request/busy/release state machine, so the cache miss and writeback paths can be exercised against a real counterpart.

Parameters:
- BLOCK_SIZE, 8, line size in bytes; power of two, at least 4; must match the cache.
- DEPTH_LINES, 1024, number of stored lines; power of two.
- LATENCY, 2, cycles memBusy stays high per transaction; at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- memAddress  input  32  byte address from the cache; offset bits [log2(BLOCK_SIZE)-1:0] ignored.
- memRead  input  1  line fill request.
- memWrite  input  1  line writeback request.
- memWriteData  input  BLOCK_SIZE*8  writeback line; byte 0 is at bits [7:0].
- memReadData  output  BLOCK_SIZE*8  fill line; byte 0 is at bits [7:0].
- memBusy  output  1  high while a transaction is in progress.

Behaviour:
- Line index is memAddress[OFF +: log2(DEPTH_LINES)], where OFF = log2(BLOCK_SIZE).
- Address bits above the index are ignored, so addresses alias modulo DEPTH_LINES lines.
- States:
  - IDLE: waiting for a request.
  - BUSY: access in progress.
  - RELEASE: access done, waiting for the request to drop.
- Reset (rst=0, asynchronous):
  - state goes to IDLE; memBusy=0; memReadData=0; latency counter=0.
  - Storage array contents are not cleared.
- IDLE:
  - On a rising edge with memRead or memWrite high, latch the index, memRead, memWrite and memWriteData.
  - Set memBusy=1, load the counter with LATENCY-1 and go to BUSY.
  - Later changes on the request inputs do not affect the transaction.
- BUSY:
  - The counter decrements on each edge.
  - On the edge where the counter is 0:
    - if a write was latched, store the latched line at the index;
    - if a read was latched, drive memReadData with the line at the index, reflecting a same-edge write (write-then-read);
    - clear memBusy and go to RELEASE.
- Timing: memBusy is high for exactly LATENCY cycles. It rises on the accept edge and falls on edge accept+LATENCY.
- memReadData:
  - valid from the falling edge of memBusy;
  - held stable until the next read completes;
  - unchanged by write-only transactions.
- RELEASE:
  - Stay while memRead or memWrite is high, so a held request is never serviced twice.
  - Go to IDLE on the first edge where both are low.
  - A new request is accepted no earlier than the edge after that.
- memRead and memWrite both high at accept: one combined transaction. The write commits first, then the read returns from the same index. memBusy is high for LATENCY cycles only, not twice.
- Reset mid-BUSY:
  - The transaction is aborted and any latched write is not committed.
  - memBusy drops immediately, without waiting for a clock edge.
- Requests arriving while in BUSY or RELEASE are ignored, not queued.

Test Plan:
1. Write, then read back, same line: write line 64'hAB_CD_12_34_56_78_90_90 at address 32'h00000004, release, then memRead at 32'h00000000.
   - Required: memBusy high for exactly 2 cycles on each transaction.
   - Required: memReadData = 64'hAB_CD_12_34_56_78_90_90 once the read's memBusy falls.
2. Aliasing: write 64'hAAAA_AAAA_AABB_CCAA at 32'h00001005, then read 32'h00003005.
   - These map to the same index when DEPTH_LINES=1024, BLOCK_SIZE=8.
   - Required: the read returns 64'hAAAA_AAAA_AABB_CCAA.
   - Required: a read at 32'h00000005 returns the scenario-1 line, a different index.
3. Combined request: memRead=memWrite=1 at 32'h00051000 with memWriteData=64'h19_09_19_09_EE_CC_EE_CC.
   - Required: a single busy window of LATENCY cycles.
   - Required: memReadData = 64'h19_09_19_09_EE_CC_EE_CC.
4. Held request: keep memRead high for 6 cycles after memBusy falls.
   - Required: no second busy pulse.
   - Required: after memRead drops for 1 cycle and is reasserted, exactly one new pulse.
5. Reset mid-BUSY: memWrite of 64'hFF..FF to a line holding 64'h0; assert rst=0 in the first busy cycle, then release reset.
   - Required: memBusy goes to 0 without a clock edge; memReadData=0.
   - Required: a subsequent read of that line returns 64'h0.
6. Latency sweep: repeat scenario 1 with LATENCY=1 and LATENCY=5.
   - Required: busy width of 1 and 5 cycles respectively, same data results.

Source files
------------

// File: rtl/dcache_line_memory.sv
// Memory-side line responder for the data cache: whole-line fills and writebacks
// behind a fixed-latency busy handshake, with a release phase so held requests are served once.
module dcache_line_memory #(
  parameter int BLOCK_SIZE  = 8,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             memAddress,
  input  logic                    memRead,
  input  logic                    memWrite,
  input  logic [BLOCK_SIZE*8-1:0] memWriteData,
  output logic [BLOCK_SIZE*8-1:0] memReadData,
  output logic                    memBusy
);
  localparam int OFF = $clog2(BLOCK_SIZE);
  localparam int IW  = $clog2(DEPTH_LINES);
  localparam int LW  = BLOCK_SIZE * 8;
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   idx_q;
  logic            rd_q, wr_q;
  logic [LW-1:0]   wdata_q;
  logic            busy_q;
  logic [LW-1:0]   rdata_q;
  logic [LW-1:0]   mem [DEPTH_LINES];
  logic            commit;

  // Tag and offset bits take no part in line selection; lines alias modulo DEPTH_LINES.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{memAddress[31:OFF+IW], memAddress[OFF-1:0]};

  assign commit      = (state_q == BUSY) && (cnt_q == '0);
  assign memBusy     = busy_q;
  assign memReadData = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (memRead || memWrite) begin
          idx_q   <= memAddress[OFF +: IW];
          rd_q    <= memRead;
          wr_q    <= memWrite;
          wdata_q <= memWriteData;
          cnt_q   <= CW'(LATENCY - 1);
          busy_q  <= 1'b1;
          state_q <= BUSY;
        end
        BUSY: if (cnt_q == '0) begin
          // Combined request: the write lands first, so the read sees the new line.
          if (rd_q) rdata_q <= wr_q ? wdata_q : mem[idx_q];
          busy_q  <= 1'b0;
          state_q <= RELEASE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        RELEASE: if (!memRead && !memWrite) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; an aborted write never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && wr_q) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_dcache_line_memory.sv
// Scoreboard bench: three responders (latency 2, 1, 5); each issued transaction queues its
// expected line, and a per-instance monitor checks busy width and read data on every busy fall.
module tb_dcache_line_memory;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr  [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [63:0] wdat  [3];
  logic [63:0] rdata [3];
  logic        busy  [3];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_line_memory #(.BLOCK_SIZE(8), .DEPTH_LINES(1024), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .memAddress(addr[0]), .memRead(rd[0]), .memWrite(wr[0]),
    .memWriteData(wdat[0]), .memReadData(rdata[0]), .memBusy(busy[0]));
  dcache_line_memory #(.BLOCK_SIZE(8), .DEPTH_LINES(1024), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .memAddress(addr[1]), .memRead(rd[1]), .memWrite(wr[1]),
    .memWriteData(wdat[1]), .memReadData(rdata[1]), .memBusy(busy[1]));
  dcache_line_memory #(.BLOCK_SIZE(8), .DEPTH_LINES(1024), .LATENCY(5)) u_lat5 (
    .clk(clk), .rst(rst), .memAddress(addr[2]), .memRead(rd[2]), .memWrite(wr[2]),
    .memWriteData(wdat[2]), .memReadData(rdata[2]), .memBusy(busy[2]));

  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    logic [63:0] q[$];
    int width = 0;
    always @(negedge clk) begin
      logic [63:0] exp_d;
      if (!rst) width = 0;
      else if (busy[g]) width++;
      else if (width > 0) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse dut%0d: got busy pulse of %0d cycles, required none", g, width);
        end else begin
          exp_d = q.pop_front();
          if (width != LAT) begin
            n_err++;
            $display("FAIL busy_width dut%0d: got %0d cycles, required %0d", g, width, LAT);
          end
          n_vec++;
          if (rdata[g] !== exp_d) begin
            n_err++;
            $display("FAIL read_data dut%0d: got %h, required %h", g, rdata[g], exp_d);
          end
        end
        width = 0;
      end
    end
  end

  task automatic push(input int d, input logic [63:0] v);
    case (d)
      0: g_mon[0].q.push_back(v);
      1: g_mon[1].q.push_back(v);
      default: g_mon[2].q.push_back(v);
    endcase
  endtask

  task automatic wait_fall(input int d);
    int  t = 0;
    bit  seen = 0;
    while (t < 40) begin
      @(negedge clk);
      t++;
      if (busy[d]) seen = 1;
      else if (seen) break;
    end
    if (t >= 40) begin
      n_vec++; n_err++;
      $display("FAIL busy_timeout dut%0d: no busy fall within 40 cycles", d);
    end
  endtask

  task automatic txn(input int d, input logic [31:0] a, input logic r, input logic w,
                     input logic [63:0] wd, input logic [63:0] exp_d);
    push(d, exp_d);
    @(negedge clk);
    addr[d] = a; rd[d] = r; wr[d] = w; wdat[d] = wd;
    wait_fall(d);
    rd[d] = 0; wr[d] = 0;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  localparam logic [63:0] L1 = 64'hAB_CD_12_34_56_78_90_90;
  localparam logic [63:0] L2 = 64'hAAAA_AAAA_AABB_CCAA;
  localparam logic [63:0] L3 = 64'h19_09_19_09_EE_CC_EE_CC;

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; rd[i] = 0; wr[i] = 0; wdat[i] = '0;
    end
    #1 rst = 1'b0;
    #20;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_busy%0d", i), {63'd0, busy[i]}, 64'd0);
      chk($sformatf("reset_rdata%0d", i), rdata[i], 64'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // write then read back, same line
    txn(0, 32'h0000_0004, 0, 1, L1, 64'd0);
    txn(0, 32'h0000_0000, 1, 0, 64'd0, L1);
    // aliasing: 0x1005 and 0x3005 share line 512
    txn(0, 32'h0000_1005, 0, 1, L2, L1);
    txn(0, 32'h0000_3005, 1, 0, 64'd0, L2);
    txn(0, 32'h0000_0005, 1, 0, 64'd0, L1);
    // combined read+write: one busy window
    txn(0, 32'h0005_1000, 1, 1, L3, L3);
    // held read: no second pulse until the request drops
    push(0, L1); push(0, L1);
    @(negedge clk);
    addr[0] = 32'h0; rd[0] = 1;
    wait_fall(0);
    repeat (6) @(negedge clk);
    rd[0] = 0;
    @(negedge clk);
    rd[0] = 1;
    wait_fall(0);
    rd[0] = 0;
    @(negedge clk);

    // reset mid-busy aborts a pending write
    txn(0, 32'h0000_0040, 0, 1, 64'd0, L1);
    @(negedge clk);
    addr[0] = 32'h0000_0040; wr[0] = 1; wdat[0] = '1;
    @(posedge clk);
    #2;
    chk("busy_before_abort", {63'd0, busy[0]}, 64'd1);
    rst = 1'b0;
    #1;
    chk("busy_async_drop", {63'd0, busy[0]}, 64'd0);
    chk("rdata_async_clear", rdata[0], 64'd0);
    wr[0] = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    txn(0, 32'h0000_0040, 1, 0, 64'd0, 64'd0);

    // latency sweep
    txn(1, 32'h0000_0004, 0, 1, L1, 64'd0);
    txn(1, 32'h0000_0000, 1, 0, 64'd0, L1);
    txn(2, 32'h0000_0004, 0, 1, L1, 64'd0);
    txn(2, 32'h0000_0000, 1, 0, 64'd0, L1);

    repeat (4) @(negedge clk);
    chk("queue0_drained", 64'(g_mon[0].q.size()), 64'd0);
    chk("queue1_drained", 64'(g_mon[1].q.size()), 64'd0);
    chk("queue2_drained", 64'(g_mon[2].q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
